mem_req_arb: RTL
================

# mem_req_arb

Single-outstanding arbiter and sequencer for the shared dcache request port. It sits between the EX0/TLB memory stage and the dcache, and serves two requesters: pipeline loads/stores (port 0) and cache-maintenance CACOP requests (port 1). Each accepted request is registered and held stable to the dcache until accepted. The block tracks the single in-flight access and routes the response back to its owner. A response belonging to a request killed by an exception flush is discarded.

## Interface
- STARVE_LIMIT, 4: consecutive port-0 grants allowed while port 1 is waiting; range 1–15.
- clk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- flush_by_exception  in  1  kill the port-0 request, in flight or pending
- p0_valid  in  1  pipeline memory request
- p0_ready  out  1  port-0 request accepted this cycle
- p0_op  in  1  1 = store, 0 = load
- p0_write_type  in  4  byte mask: 0001, 0011 or 1111
- p0_addr  in  32  byte address
- p0_wdata  in  32  store data
- p0_is_atom  in  1  LL/SC access
- p0_resp_valid  out  1  port-0 response valid
- p1_valid  in  1  CACOP request
- p1_ready  out  1  port-1 request accepted this cycle
- p1_code  in  5  CACOP code
- p1_addr  in  32  CACOP address
- p1_resp_valid  out  1  port-1 completion
- resp_rdata  out  32  response data, shared by both ports
- dc_valid  out  1  request to the dcache
- dc_ready  in  1  dcache accepts the request
- dc_op, dc_write_type, dc_addr, dc_wdata, dc_is_atom  out  1/4/32/32/1  registered request fields
- dc_cacop_en  out  1  request is a CACOP
- dc_cacop_code  out  5  CACOP code
- dc_resp_valid  in  1  dcache response
- dc_rdata  in  32  dcache response data

## Operation
- States: IDLE, REQ, WAIT.
- **IDLE:** a grant is chosen combinationally. The winner's ready is 1 in the same cycle. All fields are captured along with `owner` (0/1). Next state is REQ.
- **Priority:** port 0 wins unless port 1 is valid and `starve_cnt == STARVE_LIMIT`.
- **starve_cnt:**
  - increments on a port-0 grant while p1_valid is 1, saturating at STARVE_LIMIT;
  - clears on any port-1 grant;
  - clears when p1_valid is 0.
- **Flush in IDLE:** while flush_by_exception is 1, port 0 is not granted (p0_ready = 0). Port 1 may still be granted.
- **REQ:** dc_valid is 1 and all dc_* fields are stable. On dc_ready, next state is WAIT.
- **Flush in REQ:** if flush_by_exception is 1 and owner = 0, dc_valid drops, next state is IDLE and nothing is issued. This applies even if dc_ready is 1 in the same cycle: flush wins, and dc_ready is ignored.
- **WAIT:** on dc_resp_valid, the response goes to p{owner}_resp_valid (combinational passthrough) and next state is IDLE.
- **Flush in WAIT:** if flush_by_exception is 1 and owner = 0, the `discard` flag is set. The response is then swallowed (p0_resp_valid stays 0) and `discard` clears on the response.
- **Port 1 is never flushed.**
- **resp_rdata:** equals dc_rdata whenever either resp_valid is 1, and is 0 otherwise.
- **dc_cacop_en:** equals owner. When owner = 1, dc_op, dc_wdata, dc_is_atom and dc_write_type are 0.

## Timing
- **Reset:** state = IDLE, owner = 0, starve_cnt = 0, discard = 0. All dc_* outputs, all ready outputs, all resp_valid outputs and resp_rdata are 0.
- **Request latency:** grant in cycle N, dc_valid from N+1. Minimum turnaround is 3 cycles: grant N, accept N+1, response N+2.
- **No grant outside IDLE:** p0_ready = p1_ready = 0 in REQ and WAIT, so back-to-back requests cannot overlap.
- **Response in IDLE or REQ:** a dc_resp_valid arriving while not in WAIT is ignored.
- **Reset mid-operation:** immediate return to IDLE. An outstanding response is not tracked after reset.
- **Simultaneous events in WAIT:** flush and dc_resp_valid in the same cycle means the response is discarded and the next state is IDLE.

## Structure
- A shared package holds:
  - state encodings: IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
  - the OWNER_PIPE and OWNER_CACOP constants;
  - the write-type mask constants.
- The starvation counter is a natural sub-module, `sat_counter`: parameterised width and limit, with inc, clr and at_limit.

## Test plan
- **Single load:** p0 load, addr 0x1000. Expect p0_ready in cycle 0, dc_valid in cycle 1 with dc_ready = 1, and dc_resp_valid in cycle 3 with 0xDEADBEEF. Then p0_resp_valid = 1 and resp_rdata = 0xDEADBEEF.
- **Dcache backpressure:** dc_ready held at 0 for 5 cycles. dc_addr and dc_wdata stay constant and dc_valid stays 1 throughout. Exactly one dc_ready handshake occurs.
- **Starvation:** p0_valid and p1_valid both held at 1, STARVE_LIMIT = 4. The first 4 grants go to port 0, the 5th to port 1 with dc_cacop_en = 1, and starve_cnt then reads 0.
- **Flush in REQ:** flush in the REQ cycle with dc_ready = 1. Expect no transition to WAIT, state IDLE next cycle, and no p0_resp_valid.
- **Flush in WAIT:** flush during WAIT, response 2 cycles later. p0_resp_valid stays 0, and a new p0 request is granted in the cycle after the response.
- **Reset in WAIT:** aresetn = 0 for 1 cycle while in WAIT. All outputs are 0 next cycle, and a later stray dc_resp_valid produces no resp_valid.

Source files
------------

// File: rtl/mem_req_arb_pkg.sv
// Shared encodings for the dcache request arbiter: FSM states, owner ids
// and byte-mask constants.
package mem_req_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int   NUM_PORTS   = 2;
  localparam logic OWNER_PIPE  = 1'b0;
  localparam logic OWNER_CACOP = 1'b1;

  localparam logic [3:0] WT_NONE = 4'b0000;
  localparam logic [3:0] WT_BYTE = 4'b0001;
  localparam logic [3:0] WT_HALF = 4'b0011;
  localparam logic [3:0] WT_WORD = 4'b1111;

endpackage

// File: rtl/mem_req_arb_sat.sv
// Saturating up-counter with synchronous clear; at_limit flags count == LIMIT.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic aresetn,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [WIDTH-1:0] count_reg;

  assign at_limit = (count_reg == WIDTH'(LIMIT));

  always_ff @(posedge clk) begin
    if (!aresetn || clr) begin
      count_reg <= '0;
    end else if (inc && !at_limit) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_arb.sv
// Single-outstanding arbiter between pipeline loads/stores (port 0) and CACOP
// requests (port 1) for the shared dcache port; routes the response to its owner.
module mem_req_arb
  import mem_req_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        flush_by_exception,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic        p0_op,
  input  logic [3:0]  p0_write_type,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_is_atom,
  output logic        p0_resp_valid,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [4:0]  p1_code,
  input  logic [31:0] p1_addr,
  output logic        p1_resp_valid,
  output logic [31:0] resp_rdata,
  output logic        dc_valid,
  input  logic        dc_ready,
  output logic        dc_op,
  output logic [3:0]  dc_write_type,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  output logic        dc_is_atom,
  output logic        dc_cacop_en,
  output logic [4:0]  dc_cacop_code,
  input  logic        dc_resp_valid,
  input  logic [31:0] dc_rdata
);

  state_t      state_reg, state_next;
  logic        owner_reg;
  logic        discard_reg, discard_next;
  logic        op_reg;
  logic [3:0]  wt_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        atom_reg;
  logic [4:0]  code_reg;

  logic        grant0, grant1;
  logic        p0_req;
  logic        kill;
  logic        resp_fire, resp_drop;
  logic        starve_at_limit;
  logic [NUM_PORTS-1:0] resp_vec;

  // Only port-0 traffic is subject to exception flush.
  assign kill = flush_by_exception && (owner_reg == OWNER_PIPE);

  sat_counter #(
    .WIDTH (4),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .aresetn  (aresetn),
    .inc      (grant0 && p1_valid),
    .clr      (grant1 || !p1_valid),
    .at_limit (starve_at_limit)
  );

  always_comb begin
    state_next   = state_reg;
    discard_next = discard_reg;
    grant0       = 1'b0;
    grant1       = 1'b0;
    p0_req       = p0_valid && !flush_by_exception;
    dc_valid     = 1'b0;
    resp_fire    = 1'b0;
    resp_drop    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (p1_valid && (starve_at_limit || !p0_req)) begin
          grant1 = 1'b1;
        end else if (p0_req) begin
          grant0 = 1'b1;
        end
        if (grant0 || grant1) begin
          state_next = REQ;
        end
      end
      REQ: begin
        // A flush beats a same-cycle dc_ready: the request is never issued.
        if (kill) begin
          state_next = IDLE;
        end else begin
          dc_valid = 1'b1;
          if (dc_ready) begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (kill) begin
          discard_next = 1'b1;
        end
        if (dc_resp_valid) begin
          resp_fire    = 1'b1;
          resp_drop    = discard_reg || kill;
          discard_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!aresetn) begin
      grant0    = 1'b0;
      grant1    = 1'b0;
      dc_valid  = 1'b0;
      resp_fire = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
    if (gi == 0) begin : g_pipe
      assign resp_vec[gi] = resp_fire && (owner_reg == 1'(gi)) && !resp_drop;
    end else begin : g_cacop
      assign resp_vec[gi] = resp_fire && (owner_reg == 1'(gi));
    end
  end

  assign p0_ready      = grant0;
  assign p1_ready      = grant1;
  assign p0_resp_valid = resp_vec[0];
  assign p1_resp_valid = resp_vec[1];
  assign resp_rdata    = (|resp_vec) ? dc_rdata : 32'd0;

  assign dc_op         = op_reg;
  assign dc_write_type = wt_reg;
  assign dc_addr       = addr_reg;
  assign dc_wdata      = wdata_reg;
  assign dc_is_atom    = atom_reg;
  assign dc_cacop_en   = owner_reg;
  assign dc_cacop_code = code_reg;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_reg   <= IDLE;
      owner_reg   <= OWNER_PIPE;
      discard_reg <= 1'b0;
      op_reg      <= 1'b0;
      wt_reg      <= WT_NONE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      atom_reg    <= 1'b0;
      code_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      discard_reg <= discard_next;
      if (grant0) begin
        owner_reg <= OWNER_PIPE;
        op_reg    <= p0_op;
        wt_reg    <= p0_write_type;
        addr_reg  <= p0_addr;
        wdata_reg <= p0_wdata;
        atom_reg  <= p0_is_atom;
        code_reg  <= '0;
      end else if (grant1) begin
        // CACOP requests carry no store payload.
        owner_reg <= OWNER_CACOP;
        op_reg    <= 1'b0;
        wt_reg    <= WT_NONE;
        addr_reg  <= p1_addr;
        wdata_reg <= '0;
        atom_reg  <= 1'b0;
        code_reg  <= p1_code;
      end
    end
  end

endmodule
